mem_arbiter: RTL and testbench

Arbitrates the single shared line-wide main memory between the instruction-cache controller (refill reads only) and the data-cache controller (refill reads and dirty-line writebacks). Sits between the two cache controllers and the memory model, one request in flight at a time. Round-robin grants; completions are registered and returned to the owning requester as a one-cycle valid pulse.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory arbiter: FSM state and owner
// encodings, default widths, line-offset width and the round-robin pick.
package mem_pkg;

  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned OFFSET_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  // Picks the next owner; on a tie the requester not served last wins.
  // Only meaningful when at least one request is present.
  function automatic owner_e rr_pick(input logic i_req, input logic d_req,
                                     input owner_e last_grant);
    if (i_req && d_req) begin
      return (last_grant == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      return OWN_D;
    end else begin
      return OWN_I;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the instruction-cache (refill reads) and the
// data-cache (refill reads, writebacks) for a single line-wide memory.
// One transaction in flight; completions return as one-cycle valid pulses.
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   i_req/i_addr         : instruction refill request (level)
//   i_rdata/i_valid      : instruction line and completion pulse
//   d_req/d_we/d_addr/d_wdata : data request, 1 = writeback
//   d_rdata/d_valid      : data line and completion pulse
//   mem_enable/mem_we/mem_addr/mem_wdata : memory request, held per transaction
//   mem_rdata/mem_valid  : memory read data and completion pulse
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;   // last grant, also owner of current txn
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  // State and request/response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next state and register updates
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = rr_pick(i_req, d_req, owner_q);
          if (owner_d == OWN_I) begin
            state_d = GRANT_I;
            addr_d  = i_addr & ALIGN_MASK;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            state_d = GRANT_D;
            addr_d  = d_addr & ALIGN_MASK;
            we_d    = d_we;
            wdata_d = d_wdata;
          end
        end
      end
      GRANT_I: begin
        if (mem_valid) begin
          i_rdata_d = mem_rdata;
          state_d   = DONE;
        end
      end
      GRANT_D: begin
        if (mem_valid) begin
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset drops them at once
  always_comb begin
    mem_enable = (state_q == GRANT_I) || (state_q == GRANT_D);
    mem_we     = (state_q == GRANT_D) && we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    i_valid    = (state_q == DONE) && (owner_q == OWN_I);
    d_valid    = (state_q == DONE) && (owner_q == OWN_D);
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory model
// and scoreboards for memory requests and per-requester returned lines.
module tb_mem_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_req, d_req, d_we, i_valid, d_valid;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic [127:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic         mem_enable, mem_we, mem_valid;

  mem_arbiter #(.LINE_W(128), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mreq_t;

  mreq_t        mq[$];
  logic [127:0] iq[$], dq[$];
  logic [127:0] i_model, d_model;
  int unsigned  n_checks = 0, n_pass = 0;
  int unsigned  lat;
  bit           mem_auto;

  function automatic logic [127:0] fline(input logic [31:0] a);
    return {4{a ^ 32'hDEAD_BEEF}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Memory model: completes lat cycles after mem_enable rises
  int unsigned mcnt;
  always @(negedge clock) begin
    if (mem_auto) begin
      if (reset || !mem_enable) begin
        mcnt = 0; mem_valid = 1'b0;
      end else if (mem_valid) begin
        mem_valid = 1'b0;
      end else begin
        mcnt++;
        if (mcnt >= lat) begin
          mem_valid = 1'b1; mem_rdata = fline(mem_addr); mcnt = 0;
        end
      end
    end
  end

  // Monitor: request scoreboard, enable length, pulse shape, returned lines
  bit          prev_en = 0, prev_iv = 0, prev_dv = 0;
  int unsigned en_cnt = 0, n_grants = 0, i_pulses = 0, d_pulses = 0;
  mreq_t       mon_e;
  always @(negedge clock) begin
    if (mem_enable && !prev_en) begin
      n_grants++;
      chk("grant_expected", 128'(mq.size() != 0), 128'd1);
      if (mq.size() != 0) begin
        mon_e = mq.pop_front();
        chk("grant_we", mem_we, mon_e.we);
        chk("grant_addr", mem_addr, mon_e.addr);
        if (mon_e.we) chk("grant_wdata", mem_wdata, mon_e.wdata);
      end
    end
    if (mem_enable) en_cnt++;
    else begin
      if (prev_en && !reset) chk("enable_cycles", en_cnt, lat);
      en_cnt = 0;
    end
    if (i_valid) begin
      i_pulses++;
      chk("gap_enable_i", mem_enable, 0);
      chk("i_pulse_width", prev_iv, 0);
      chk("i_pulse_expected", 128'(iq.size() != 0), 128'd1);
      if (iq.size() != 0) chk("i_rdata", i_rdata, iq.pop_front());
    end
    if (d_valid) begin
      d_pulses++;
      chk("gap_enable_d", mem_enable, 0);
      chk("d_pulse_width", prev_dv, 0);
      chk("d_pulse_expected", 128'(dq.size() != 0), 128'd1);
      if (dq.size() != 0) chk("d_rdata", d_rdata, dq.pop_front());
    end
    prev_en = mem_enable; prev_iv = i_valid; prev_dv = d_valid;
  end

  task automatic issue_i(input logic [31:0] a);
    i_addr = a; i_req = 1'b1;
    mq.push_back('{1'b0, a & ~32'hF, '0});
    i_model = fline(a & ~32'hF);
    iq.push_back(i_model);
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [127:0] wd);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    mq.push_back('{we, a & ~32'hF, wd});
    if (!we) d_model = fline(a & ~32'hF);
    dq.push_back(d_model);
  endtask

  task automatic wait_valid(input bit want_i, input string tag);
    bit got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clock);
      got = want_i ? i_valid : d_valid;
    end
    chk(tag, 128'(got), 128'd1);
  endtask

  initial begin
    int unsigned g0, p0, cnt;
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_valid = 0; mem_rdata = '0; mem_auto = 1; lat = 3;
    i_model = '0; d_model = '0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Both requesters continuously: I first, then strict alternation
    mq.push_back('{1'b0, 32'h1100, '0});
    mq.push_back('{1'b0, 32'h3300, '0});
    mq.push_back('{1'b0, 32'h1100, '0});
    mq.push_back('{1'b0, 32'h3300, '0});
    i_model = fline(32'h1100); d_model = fline(32'h3300);
    iq.push_back(i_model); iq.push_back(i_model);
    dq.push_back(d_model); dq.push_back(d_model);
    i_addr = 32'h1108; i_req = 1; d_addr = 32'h3304; d_we = 0; d_req = 1;
    cnt = 0;
    for (int k = 0; k < 400 && cnt < 4; k++) begin
      @(negedge clock);
      if (i_valid || d_valid) cnt++;
    end
    chk("alt_four_done", cnt, 4);
    i_req = 0; d_req = 0;
    repeat (3) @(negedge clock);

    // Instruction refill, latency 5, unaligned address
    lat = 5;
    issue_i(32'h0000_1234);
    wait_valid(1, "i_read_timeout");
    i_req = 0;
    chk("i_rdata_after", i_rdata, fline(32'h0000_1230));
    repeat (2) @(negedge clock);

    // Writeback: d_rdata must keep the last read line
    lat = 4;
    issue_d(1, 32'h0000_2040, {16{8'hA5}});
    wait_valid(0, "d_wb_timeout");
    d_req = 0;
    chk("d_rdata_kept_wb", d_rdata, fline(32'h3300));
    repeat (2) @(negedge clock);

    // Requester holds req through DONE: no duplicate grant
    lat = 2;
    issue_i(32'h0000_1500);
    wait_valid(1, "hold_timeout");
    @(negedge clock);
    i_req = 0;
    g0 = n_grants;
    repeat (8) @(negedge clock);
    chk("no_dup_grant", n_grants, g0);
    issue_i(32'h0000_1600);
    wait_valid(1, "regrant_timeout");
    i_req = 0;
    repeat (2) @(negedge clock);

    // Reset two cycles into GRANT_D
    lat = 20;
    d_we = 0; d_addr = 32'h0000_3000; d_req = 1;
    mq.push_back('{1'b0, 32'h3000, '0});
    cnt = 0;
    for (int k = 0; k < 50 && !mem_enable; k++) @(negedge clock);
    chk("abort_granted", mem_enable, 1);
    repeat (2) @(negedge clock);
    p0 = d_pulses;
    #1 reset = 1'b1;
    #1;
    chk("abort_mem_enable", mem_enable, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_d_valid", d_valid, 0);
    chk("abort_i_rdata", i_rdata, 0);
    chk("abort_d_rdata", d_rdata, 0);
    d_req = 0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    i_model = '0; d_model = '0;
    repeat (3) @(negedge clock);
    chk("abort_no_d_valid", d_pulses, p0);

    // After reset release: simultaneous requests, instruction wins
    lat = 3;
    issue_i(32'h0000_1ABC);
    issue_d(0, 32'h0000_2D44, '0);
    wait_valid(1, "post_rst_i_timeout");
    i_req = 0;
    wait_valid(0, "post_rst_d_timeout");
    d_req = 0;
    repeat (3) @(negedge clock);

    // Spurious mem_valid in IDLE
    g0 = n_grants; p0 = i_pulses + d_pulses;
    mem_auto = 0;
    mem_valid = 1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clock);
    mem_valid = 0;
    mem_auto = 1;
    repeat (3) @(negedge clock);
    chk("spur_no_pulse", i_pulses + d_pulses, p0);
    chk("spur_no_grant", n_grants, g0);
    chk("spur_i_rdata", i_rdata, i_model);
    chk("spur_d_rdata", d_rdata, d_model);

    chk("mq_drained", mq.size(), 0);
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
